// File: rtl/ipv4_arp_lut.sv
// Next-hop ARP resolution: fully associative IPv4 -> MAC table with a
// register-interface manager, a post-reset clear sweep and a small
// fall-through result FIFO popped by the output-port-lookup FSM.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_CLEAR | sweeping row[idx] to zero; management stalled, lookups miss
// S_IDLE  | management reads/writes served, lookups use the table
module ipv4_arp_lut #(
  parameter int ARP_LUT_ROWS        = 32,
  parameter int ARP_LUT_ROW_BITS    = 5,
  parameter int OUT_FIFO_DEPTH_BITS = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_arp_lut_rd_req,
  output logic                        o_arp_lut_rd_ack,
  input  logic [ARP_LUT_ROW_BITS-1:0] i_arp_lut_rd_addr,
  output logic [31:0]                 o_arp_lut_rd_ipv4,
  output logic [31:0]                 o_arp_lut_rd_mac_hi,
  output logic [31:0]                 o_arp_lut_rd_mac_lo,
  input  logic                        i_arp_lut_wr_req,
  output logic                        o_arp_lut_wr_ack,
  input  logic [ARP_LUT_ROW_BITS-1:0] i_arp_lut_wr_addr,
  input  logic [31:0]                 i_arp_lut_wr_ipv4,
  input  logic [31:0]                 i_arp_lut_wr_mac_hi,
  input  logic [31:0]                 i_arp_lut_wr_mac_lo,
  input  logic [31:0]                 i_nh,
  input  logic [31:0]                 i_daddr,
  input  logic                        i_nh_valid,
  input  logic                        i_rd_from_magic,
  output logic [47:0]                 o_arp_lut_mac,
  output logic                        o_arp_lut_hit,
  output logic                        o_arp_lut_valid,
  output logic                        o_arp_lut_busy,
  output logic [31:0]                 o_arp_lut_miss_cnt,
  output logic [31:0]                 o_arp_lut_drop_cnt
);

  localparam int FIFO_DEPTH = 2 ** OUT_FIFO_DEPTH_BITS;
  localparam logic [ARP_LUT_ROW_BITS-1:0] LAST_ROW = ARP_LUT_ROW_BITS'(ARP_LUT_ROWS - 1);
  localparam logic [OUT_FIFO_DEPTH_BITS:0] FIFO_FULL_CNT = (OUT_FIFO_DEPTH_BITS + 1)'(FIFO_DEPTH);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t                      state_q, state_d;
  logic [ARP_LUT_ROW_BITS-1:0] idx_q, idx_d;
  logic [ARP_LUT_ROW_BITS-1:0] rd_sel_q;
  logic                        rd_ack_q, wr_ack_q;
  logic                        rd_accept, wr_accept;

  logic [31:0]                 tbl_ip_q  [ARP_LUT_ROWS];
  logic [47:0]                 tbl_mac_q [ARP_LUT_ROWS];
  logic                        tbl_we;
  logic [ARP_LUT_ROW_BITS-1:0] tbl_waddr;
  logic [31:0]                 tbl_wip;
  logic [47:0]                 tbl_wmac;

  logic [31:0]                 lu_key;
  logic                        lu_hit;
  logic [47:0]                 lu_mac;
  logic                        res_vld_q, res_hit_q;
  logic [47:0]                 res_mac_q;
  logic [31:0]                 miss_cnt_q, drop_cnt_q;

  logic [48:0]                    fifo_mem_q [FIFO_DEPTH];
  logic [OUT_FIFO_DEPTH_BITS-1:0] fifo_wp_q, fifo_rp_q;
  logic [OUT_FIFO_DEPTH_BITS:0]   fifo_cnt_q;
  logic                           fifo_full, fifo_empty, fifo_pop, fifo_push, fifo_drop;

  // Upper half of the mac_hi write word carries no MAC bits.
  logic unused_mac_hi;
  assign unused_mac_hi = ^i_arp_lut_wr_mac_hi[31:16];

  // Next-state and table-write selection: sweep writes in CLEAR, management in IDLE.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rd_accept = 1'b0;
    wr_accept = 1'b0;
    tbl_we    = 1'b0;
    tbl_waddr = idx_q;
    tbl_wip   = 32'h0;
    tbl_wmac  = 48'h0;
    if (state_q == S_CLEAR) begin
      tbl_we = 1'b1;
      idx_d  = idx_q + 1'b1;
      if (idx_q == LAST_ROW) state_d = S_IDLE;
    end else begin
      // A held request is not re-accepted during its own ack cycle; read beats write.
      rd_accept = i_arp_lut_rd_req && !rd_ack_q;
      wr_accept = i_arp_lut_wr_req && !wr_ack_q && !rd_accept;
      if (wr_accept) begin
        tbl_we    = 1'b1;
        tbl_waddr = i_arp_lut_wr_addr;
        tbl_wip   = i_arp_lut_wr_ipv4;
        tbl_wmac  = {i_arp_lut_wr_mac_hi[15:0], i_arp_lut_wr_mac_lo};
      end
    end
  end

  // FSM state, sweep index and management handshake registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_CLEAR;
      idx_q    <= '0;
      rd_sel_q <= '0;
      rd_ack_q <= 1'b0;
      wr_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rd_ack_q <= rd_accept;
      wr_ack_q <= wr_accept;
      if (rd_accept) rd_sel_q <= i_arp_lut_rd_addr;
    end
  end

  // Table storage; the clear sweep stands in for a reset of the rows.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      tbl_ip_q[tbl_waddr]  <= tbl_wip;
      tbl_mac_q[tbl_waddr] <= tbl_wmac;
    end
  end

  assign o_arp_lut_rd_ack    = rd_ack_q;
  assign o_arp_lut_wr_ack    = wr_ack_q;
  assign o_arp_lut_rd_ipv4   = tbl_ip_q[rd_sel_q];
  assign o_arp_lut_rd_mac_hi = {16'h0, tbl_mac_q[rd_sel_q][47:32]};
  assign o_arp_lut_rd_mac_lo = tbl_mac_q[rd_sel_q][31:0];
  assign o_arp_lut_busy      = (state_q == S_CLEAR);

  // Associative compare; scanning downward lets the lowest matching row win.
  always_comb begin
    lu_key = (i_nh == 32'h0) ? i_daddr : i_nh;
    lu_hit = 1'b0;
    lu_mac = 48'h0;
    for (int i = ARP_LUT_ROWS - 1; i >= 0; i--) begin
      if (tbl_ip_q[i] == lu_key && tbl_ip_q[i] != 32'h0) begin
        lu_hit = 1'b1;
        lu_mac = tbl_mac_q[i];
      end
    end
    if (state_q == S_CLEAR) begin
      lu_hit = 1'b0;
      lu_mac = 48'h0;
    end
  end

  assign fifo_full  = (fifo_cnt_q == FIFO_FULL_CNT);
  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_pop   = i_rd_from_magic && !fifo_empty;
  assign fifo_push  = res_vld_q && (!fifo_full || fifo_pop);
  assign fifo_drop  = res_vld_q && fifo_full && !fifo_pop;

  // Registered lookup result and saturating miss/drop counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_vld_q  <= 1'b0;
      res_hit_q  <= 1'b0;
      res_mac_q  <= 48'h0;
      miss_cnt_q <= 32'h0;
      drop_cnt_q <= 32'h0;
    end else begin
      res_vld_q <= i_nh_valid;
      if (i_nh_valid) begin
        res_hit_q <= lu_hit;
        res_mac_q <= lu_mac;
        if (!lu_hit && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'h1;
      end
      if (fifo_drop && drop_cnt_q != 32'hFFFF_FFFF) drop_cnt_q <= drop_cnt_q + 32'h1;
    end
  end

  // Result FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_wp_q  <= '0;
      fifo_rp_q  <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (fifo_push) fifo_wp_q <= fifo_wp_q + 1'b1;
      if (fifo_pop)  fifo_rp_q <= fifo_rp_q + 1'b1;
      if (fifo_push && !fifo_pop)      fifo_cnt_q <= fifo_cnt_q + 1'b1;
      else if (fifo_pop && !fifo_push) fifo_cnt_q <= fifo_cnt_q - 1'b1;
    end
  end

  // Result FIFO storage; on full push+pop the slot written is the one leaving.
  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem_q[fifo_wp_q] <= {res_hit_q, res_mac_q};
  end

  assign {o_arp_lut_hit, o_arp_lut_mac} = fifo_mem_q[fifo_rp_q];
  assign o_arp_lut_valid    = !fifo_empty;
  assign o_arp_lut_miss_cnt = miss_cnt_q;
  assign o_arp_lut_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_ipv4_arp_lut.sv
// Bench for ipv4_arp_lut: reference table model plus result scoreboard.
module tb_ipv4_arp_lut;
  localparam int ROWS = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd_req = 1'b0, wr_req = 1'b0, nh_valid = 1'b0, rd_from_magic = 1'b0;
  logic [4:0]  rd_addr = '0, wr_addr = '0;
  logic [31:0] wr_ipv4 = '0, wr_mac_hi = '0, wr_mac_lo = '0, nh = '0, daddr = '0;
  logic        rd_ack, wr_ack, hit, valid, busy;
  logic [31:0] rd_ipv4, rd_mac_hi, rd_mac_lo, miss_cnt, drop_cnt;
  logic [47:0] mac;

  int          n_cmp = 0, n_bad = 0, cyc = 0;
  logic [48:0] sb_q[$];
  logic [31:0] m_ip  [ROWS];
  logic [47:0] m_mac [ROWS];
  int unsigned m_miss = 0, m_drop = 0;

  always #5 clk = ~clk;

  ipv4_arp_lut dut (
    .clk(clk), .reset(reset),
    .i_arp_lut_rd_req(rd_req), .o_arp_lut_rd_ack(rd_ack), .i_arp_lut_rd_addr(rd_addr),
    .o_arp_lut_rd_ipv4(rd_ipv4), .o_arp_lut_rd_mac_hi(rd_mac_hi), .o_arp_lut_rd_mac_lo(rd_mac_lo),
    .i_arp_lut_wr_req(wr_req), .o_arp_lut_wr_ack(wr_ack), .i_arp_lut_wr_addr(wr_addr),
    .i_arp_lut_wr_ipv4(wr_ipv4), .i_arp_lut_wr_mac_hi(wr_mac_hi), .i_arp_lut_wr_mac_lo(wr_mac_lo),
    .i_nh(nh), .i_daddr(daddr), .i_nh_valid(nh_valid), .i_rd_from_magic(rd_from_magic),
    .o_arp_lut_mac(mac), .o_arp_lut_hit(hit), .o_arp_lut_valid(valid), .o_arp_lut_busy(busy),
    .o_arp_lut_miss_cnt(miss_cnt), .o_arp_lut_drop_cnt(drop_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_clear();
    for (int i = 0; i < ROWS; i++) begin
      m_ip[i]  = 32'h0;
      m_mac[i] = 48'h0;
    end
  endtask

  function automatic logic [48:0] model_lookup(input logic [31:0] a_nh, input logic [31:0] a_da,
                                               input bit clearing);
    logic [31:0] key;
    key = (a_nh == 32'h0) ? a_da : a_nh;
    if (clearing) return 49'h0;
    for (int i = 0; i < ROWS; i++)
      if (m_ip[i] != 32'h0 && m_ip[i] == key) return {1'b1, m_mac[i]};
    return 49'h0;
  endfunction

  // One-cycle lookup strobe; the expected result is queued unless it will be dropped.
  task automatic do_lookup(input logic [31:0] a_nh, input logic [31:0] a_da,
                           input bit clearing, input bit stored);
    logic [48:0] exp;
    exp = model_lookup(a_nh, a_da, clearing);
    if (!exp[48]) m_miss++;
    if (stored) sb_q.push_back(exp);
    else m_drop++;
    nh = a_nh;
    daddr = a_da;
    nh_valid = 1'b1;
    tick();
    nh_valid = 1'b0;
  endtask

  // Pop every queued result, comparing the FIFO head against the scoreboard.
  task automatic drain(input string tag);
    logic [48:0] exp;
    int budget = 40;
    while (sb_q.size() > 0 && budget > 0) begin
      if (valid) begin
        exp = sb_q.pop_front();
        n_cmp++;
        if ({hit, mac} !== exp) begin
          n_bad++;
          $display("FAIL %s head: got hit=%b mac=%h, expected hit=%b mac=%h", tag, hit, mac, exp[48], exp[47:0]);
        end
        rd_from_magic = 1'b1;
        tick();
        rd_from_magic = 1'b0;
      end else begin
        tick();
      end
      budget--;
    end
    if (sb_q.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: %0d results never appeared", tag, sb_q.size());
      sb_q.delete();
    end
    n_cmp++;
    if (valid !== 1'b0) begin n_bad++; $display("FAIL %s empty_after_drain: valid=%b, expected 0", tag, valid); end
  endtask

  task automatic wr_row(input logic [4:0] a, input logic [31:0] ip, input logic [31:0] hi, input logic [31:0] lo);
    int budget = 64;
    wr_req = 1'b1; wr_addr = a; wr_ipv4 = ip; wr_mac_hi = hi; wr_mac_lo = lo;
    do begin tick(); budget--; end while (!wr_ack && budget > 0);
    n_cmp++;
    if (wr_ack !== 1'b1) begin n_bad++; $display("FAIL wr_row timeout: wr_ack=%b, expected 1", wr_ack); end
    wr_req = 1'b0;
    m_ip[a] = ip;
    m_mac[a] = {hi[15:0], lo};
    tick();
  endtask

  task automatic test_reset();
    int n = 0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    model_clear();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %b, expected 1", busy); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b, expected 0", valid); end
    n_cmp++; if ({rd_ack, wr_ack} !== 2'b00) begin n_bad++; $display("FAIL reset_acks: got %b, expected 00", {rd_ack, wr_ack}); end
    n_cmp++; if ({miss_cnt, drop_cnt} !== 64'h0) begin n_bad++; $display("FAIL reset_cnts: got %h/%h, expected 0/0", miss_cnt, drop_cnt); end
    while (busy && n < 100) begin n++; tick(); end
    n_cmp++; if (n != 32) begin n_bad++; $display("FAIL sweep_len: busy for %0d cycles, expected 32", n); end
    rd_req = 1'b1; rd_addr = 5'd5;
    n_cmp++; if (rd_ack !== 1'b0) begin n_bad++; $display("FAIL rd_ack_early: got %b, expected 0", rd_ack); end
    tick();
    rd_req = 1'b0;
    n_cmp++; if (rd_ack !== 1'b1) begin n_bad++; $display("FAIL rd_ack_timing: got %b, expected 1", rd_ack); end
    n_cmp++; if ({rd_ipv4, rd_mac_hi, rd_mac_lo} !== 96'h0) begin
      n_bad++; $display("FAIL rd_row5_cleared: got %h %h %h, expected all 0", rd_ipv4, rd_mac_hi, rd_mac_lo); end
    tick();
    n_cmp++; if (rd_ack !== 1'b0) begin n_bad++; $display("FAIL rd_ack_pulse: got %b, expected 0", rd_ack); end
  endtask

  task automatic test_basic_hit();
    wr_req = 1'b1; wr_addr = 5'd3; wr_ipv4 = 32'h0A00_0001; wr_mac_hi = 32'h0000_0011; wr_mac_lo = 32'h2233_4455;
    tick();
    wr_req = 1'b0;
    n_cmp++; if (wr_ack !== 1'b1) begin n_bad++; $display("FAIL wr_ack_timing: got %b, expected 1", wr_ack); end
    m_ip[3] = 32'h0A00_0001; m_mac[3] = 48'h0011_2233_4455;
    tick();
    do_lookup(32'h0A00_0001, 32'h0, 1'b0, 1'b1);
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL valid_latency1: got %b, expected 0", valid); end
    tick();
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL valid_latency2: got %b, expected 1", valid); end
    drain("basic");
  endtask

  task automatic test_daddr_and_miss();
    do_lookup(32'h0, 32'h0A00_0001, 1'b0, 1'b1);
    do_lookup(32'h0A00_0002, 32'h0A00_0001, 1'b0, 1'b1);
    drain("daddr_miss");
    n_cmp++; if (miss_cnt !== m_miss) begin n_bad++; $display("FAIL miss_cnt1: got %0d, expected %0d", miss_cnt, m_miss); end
    do_lookup(32'h0, 32'h0, 1'b0, 1'b1);
    drain("zero_key");
    n_cmp++; if (miss_cnt !== m_miss) begin n_bad++; $display("FAIL miss_cnt2: got %0d, expected %0d", miss_cnt, m_miss); end
  endtask

  task automatic test_priority();
    logic [31:0] ip, hi, lo;
    int budget = 64;
    wr_row(5'd9, 32'hC0A8_0101, 32'hFFFF_9999, 32'h9999_9999);
    wr_row(5'd4, 32'hC0A8_0101, 32'h1234_4444, 32'h4444_4444);
    do_lookup(32'hC0A8_0101, 32'h0, 1'b0, 1'b1);
    drain("priority");
    rd_req = 1'b1; rd_addr = 5'd9;
    do begin tick(); budget--; end while (!rd_ack && budget > 0);
    ip = rd_ipv4; hi = rd_mac_hi; lo = rd_mac_lo;
    rd_req = 1'b0;
    n_cmp++; if ({rd_ack, ip, hi, lo} !== {1'b1, 32'hC0A8_0101, 32'h0000_9999, 32'h9999_9999}) begin
      n_bad++; $display("FAIL rd_row9: got ack=%b %h %h %h, expected 1 c0a80101 00009999 99999999", rd_ack, ip, hi, lo); end
    tick();
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 5; i++) do_lookup((i % 2 == 0) ? 32'h0A00_0001 : 32'h0A00_00F0, 32'h0, 1'b0, i < 4);
    tick();
    n_cmp++; if (drop_cnt !== m_drop) begin n_bad++; $display("FAIL drop_cnt: got %0d, expected %0d", drop_cnt, m_drop); end
    rd_req = 1'b1; rd_addr = 5'd3;
    wr_req = 1'b1; wr_addr = 5'd12; wr_ipv4 = 32'h0B00_0001; wr_mac_hi = 32'h0000_ABCD; wr_mac_lo = 32'h0102_0304;
    tick();
    rd_req = 1'b0;
    n_cmp++; if ({rd_ack, wr_ack} !== 2'b10) begin n_bad++; $display("FAIL rd_wins: got rd/wr ack %b, expected 10", {rd_ack, wr_ack}); end
    n_cmp++; if (rd_ipv4 !== 32'h0A00_0001) begin n_bad++; $display("FAIL rd_row3: got %h, expected 0a000001", rd_ipv4); end
    tick();
    wr_req = 1'b0;
    n_cmp++; if ({rd_ack, wr_ack} !== 2'b01) begin n_bad++; $display("FAIL wr_pending: got rd/wr ack %b, expected 01", {rd_ack, wr_ack}); end
    m_ip[12] = 32'h0B00_0001; m_mac[12] = 48'hABCD_0102_0304;
    tick();
    drain("fifo_full");
  endtask

  task automatic test_full_push_pop();
    logic [48:0] exp;
    do_lookup(32'h0B00_0001, 32'h0, 1'b0, 1'b1);
    do_lookup(32'h0A00_0001, 32'h0, 1'b0, 1'b1);
    do_lookup(32'h0707_0707, 32'h0, 1'b0, 1'b1);
    do_lookup(32'h0, 32'hC0A8_0101, 1'b0, 1'b1);
    do_lookup(32'h0B00_0001, 32'h0, 1'b0, 1'b1);
    exp = sb_q.pop_front();
    n_cmp++; if ({valid, hit, mac} !== {1'b1, exp}) begin
      n_bad++; $display("FAIL full_head: got v=%b hit=%b mac=%h, expected v=1 hit=%b mac=%h", valid, hit, mac, exp[48], exp[47:0]); end
    rd_from_magic = 1'b1;
    tick();
    rd_from_magic = 1'b0;
    n_cmp++; if (drop_cnt !== m_drop) begin n_bad++; $display("FAIL push_pop_nodrop: drop_cnt %0d, expected %0d", drop_cnt, m_drop); end
    drain("push_pop_full");
  endtask

  task automatic test_write_collision();
    sb_q.push_back(model_lookup(32'h0A00_0001, 32'h0, 1'b0));
    wr_req = 1'b1; wr_addr = 5'd3; wr_ipv4 = 32'h0A00_0001; wr_mac_hi = 32'h0000_DEAD; wr_mac_lo = 32'hBEEF_0001;
    nh = 32'h0A00_0001; daddr = 32'h0; nh_valid = 1'b1;
    tick();
    nh_valid = 1'b0; wr_req = 1'b0;
    n_cmp++; if (wr_ack !== 1'b1) begin n_bad++; $display("FAIL coll_wr_ack: got %b, expected 1", wr_ack); end
    m_mac[3] = 48'hDEAD_BEEF_0001;
    do_lookup(32'h0A00_0001, 32'h0, 1'b0, 1'b1);
    drain("collision");
  endtask

  task automatic test_reset_mid_sweep();
    int c0, n = 0;
    bit any_ack = 1'b0;
    do_lookup(32'h0A00_0001, 32'h0, 1'b0, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb_q.delete(); m_miss = 0; m_drop = 0;
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_flush1: valid=%b, expected 0", valid); end
    c0 = cyc;
    rd_req = 1'b1; rd_addr = 5'd3;
    wr_req = 1'b1; wr_addr = 5'd7; wr_ipv4 = 32'h0C00_0001; wr_mac_hi = 32'h0; wr_mac_lo = 32'h77;
    do_lookup(32'h0A00_0001, 32'h0, 1'b1, 1'b1);
    drain("clear_miss");
    any_ack |= rd_ack | wr_ack;
    n_cmp++; if (miss_cnt !== m_miss) begin n_bad++; $display("FAIL clear_miss_cnt: got %0d, expected %0d", miss_cnt, m_miss); end
    while (cyc - c0 < 9) begin tick(); any_ack |= rd_ack | wr_ack; end
    do_lookup(32'h0B00_0001, 32'h0, 1'b1, 1'b1);
    tick();
    any_ack |= rd_ack | wr_ack;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb_q.delete(); m_miss = 0;
    model_clear();
    n_cmp++; if ({valid, busy} !== 2'b01) begin n_bad++; $display("FAIL reset_flush2: valid/busy %b, expected 01", {valid, busy}); end
    n_cmp++; if (miss_cnt !== 32'h0) begin n_bad++; $display("FAIL reset_miss_zero: got %0d, expected 0", miss_cnt); end
    while (busy && n < 100) begin n++; tick(); if (busy) any_ack |= rd_ack | wr_ack; end
    n_cmp++; if (n != 32) begin n_bad++; $display("FAIL resweep_len: busy %0d cycles, expected 32", n); end
    n_cmp++; if (any_ack !== 1'b0) begin n_bad++; $display("FAIL ack_in_clear: ack seen=%b, expected 0", any_ack); end
    tick();
    rd_req = 1'b0;
    n_cmp++; if ({rd_ack, wr_ack, rd_ipv4} !== {2'b10, 32'h0}) begin
      n_bad++; $display("FAIL post_clear_rd: ack rd/wr %b ipv4 %h, expected 10 00000000", {rd_ack, wr_ack}, rd_ipv4); end
    tick();
    wr_req = 1'b0;
    n_cmp++; if (wr_ack !== 1'b1) begin n_bad++; $display("FAIL post_clear_wr: got %b, expected 1", wr_ack); end
    m_ip[7] = 32'h0C00_0001; m_mac[7] = 48'h77;
    tick();
    do_lookup(32'h0C00_0001, 32'h0, 1'b0, 1'b1);
    drain("post_clear");
  endtask

  initial begin
    test_reset();
    test_basic_hit();
    test_daddr_and_miss();
    test_priority();
    test_fifo_full();
    test_full_push_pop();
    test_write_collision();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
